// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the multi-channel LED pattern generator.
// Mode and per-channel FSM encodings plus the gap length multiplier.
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_OFF,
      MODE_ON,
      MODE_BLINK,
      MODE_BURST
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_GAP
   } state_e;

   localparam int GAP_MULT = 4;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Host-side configuration write bundle for led_pattern_gen.
interface led_pattern_gen_if #(
   parameter int N_CH    = 4,
   parameter int HALF_W  = 16,
   parameter int BURST_W = 4
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic               cfg_we;
   logic [CH_W-1:0]    cfg_ch;
   logic [1:0]         cfg_mode;
   logic [HALF_W-1:0]  cfg_half;
   logic [BURST_W-1:0] cfg_burst;

   modport master (
      output cfg_we, cfg_ch, cfg_mode,
      output cfg_half, cfg_burst
   );

   modport slave (
      input cfg_we, cfg_ch, cfg_mode,
      input cfg_half, cfg_burst
   );

endinterface

// File: rtl/led_pattern_gen_ch.sv
// One LED channel: config registers, phase/flash counters and FSM.
// Advances only on the shared tick; a write overrides that tick.
module led_pattern_ch
   import led_pattern_pkg::*;
#(
   parameter int HALF_W  = 16,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_i,
   input  logic               we_i,
   input  logic [1:0]         mode_i,
   input  logic [HALF_W-1:0]  half_i,
   input  logic [BURST_W-1:0] burst_i,
   output logic               led_o,
   output logic               done_o
);
   localparam int PH_W = HALF_W + 2;

   mode_e              mode_q;
   state_e             state_q;
   logic [HALF_W-1:0]  half_q;
   logic [BURST_W-1:0] burst_q;
   logic [PH_W-1:0]    phase_q;
   logic [BURST_W-1:0] flash_q;
   logic               led_q;
   logic               done_q;

   logic [HALF_W-1:0]  half_d;
   logic [PH_W-1:0]    h_end;
   logic [PH_W-1:0]    gap_end;
   logic [PH_W-1:0]    phase_d;
   logic [BURST_W-1:0] flash_d;

   assign half_d  = (half_i == '0) ? HALF_W'(1) : half_i;
   assign h_end   = {2'b00, half_q} - PH_W'(1);
   assign gap_end = PH_W'(GAP_MULT) * {2'b00, half_q}
                  - PH_W'(1);
   // saturate rather than wrap
   assign phase_d = (&phase_q) ? phase_q
                  : phase_q + PH_W'(1);
   assign flash_d = flash_q + BURST_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_OFF;
         state_q <= S_IDLE;
         half_q  <= HALF_W'(1);
         burst_q <= '0;
         phase_q <= '0;
         flash_q <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (we_i) begin
            mode_q  <= mode_e'(mode_i);
            half_q  <= half_d;
            burst_q <= burst_i;
            phase_q <= '0;
            flash_q <= '0;
            unique case (mode_e'(mode_i))
               MODE_ON, MODE_BLINK: begin
                  state_q <= S_ON;
                  led_q   <= 1'b1;
               end
               MODE_BURST: begin
                  state_q <= (burst_i != '0) ? S_ON : S_IDLE;
                  led_q   <= (burst_i != '0);
               end
               default: begin
                  state_q <= S_IDLE;
                  led_q   <= 1'b0;
               end
            endcase
         end else if (tick_i) begin
            unique case (state_q)
               S_ON: begin
                  if (mode_q != MODE_ON) begin
                     if (phase_q == h_end) begin
                        state_q <= S_OFF;
                        phase_q <= '0;
                        led_q   <= 1'b0;
                     end else begin
                        phase_q <= phase_d;
                     end
                  end
               end
               S_OFF: begin
                  if (phase_q == h_end) begin
                     phase_q <= '0;
                     if (mode_q == MODE_BURST) begin
                        flash_q <= flash_d;
                     end
                     if (mode_q == MODE_BURST &&
                         flash_d == burst_q) begin
                        state_q <= S_GAP;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_ON;
                        led_q   <= 1'b1;
                     end
                  end else begin
                     phase_q <= phase_d;
                  end
               end
               S_GAP: begin
                  if (phase_q == gap_end) begin
                     state_q <= S_ON;
                     phase_q <= '0;
                     flash_q <= '0;
                     led_q   <= 1'b1;
                  end else begin
                     phase_q <= phase_d;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign led_o  = led_q;
   assign done_o = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler + N_CH channels.
// Define LED_PATTERN_ACTIVE_LOW_EN for inverted (active-low) led drive.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int HALF_W  = 16,
   parameter int BURST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   led_pattern_gen_if.slave cfg,
   output logic [N_CH-1:0] led,
   output logic [N_CH-1:0] burst_done
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt_q;
   logic             tick;
   logic [N_CH-1:0]  led_int;

   assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic we;
      // out-of-range channels match no instance
      assign we = cfg.cfg_we &&
                  (int'(cfg.cfg_ch) == i);

      led_pattern_ch #(
         .HALF_W  (HALF_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .tick_i  (tick),
         .we_i    (we),
         .mode_i  (cfg.cfg_mode),
         .half_i  (cfg.cfg_half),
         .burst_i (cfg.cfg_burst),
         .led_o   (led_int[i]),
         .done_o  (burst_done[i])
      );
   end

`ifdef LED_PATTERN_ACTIVE_LOW_EN
   assign led = ~led_int;
`else
   assign led = led_int;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random writes
// checked every cycle against a tick-count based reference model.
module tb_led_pattern_gen;
   localparam int N_CH    = 3;
   localparam int CLK_HZ  = 4000;
   localparam int TICK_HZ = 1000;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int HALF_W  = 16;
   localparam int BURST_W = 4;
   localparam int CH_W    = 2;

`ifdef LED_PATTERN_ACTIVE_LOW_EN
   localparam logic [N_CH-1:0] INV = '1;
`else
   localparam logic [N_CH-1:0] INV = '0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led_pattern_gen_if #(
      .N_CH(N_CH), .HALF_W(HALF_W), .BURST_W(BURST_W)
   ) cfg ();

   logic [N_CH-1:0] led;
   logic [N_CH-1:0] burst_done;
   logic [N_CH-1:0] ledhi;
   assign ledhi = led ^ INV;

   led_pattern_gen #(
      .N_CH(N_CH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
      .HALF_W(HALF_W), .BURST_W(BURST_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg        (cfg),
      .led        (led),
      .burst_done (burst_done)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int m_mode [N_CH];
   int m_h    [N_CH];
   int m_b    [N_CH];
   int m_t    [N_CH];
   logic [N_CH-1:0] exp_led;
   logic [N_CH-1:0] exp_done;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d",
                  tag, got, exp, cyc);
      end
   endtask

   // led as a function of ticks elapsed since the last write
   function automatic logic model_led(int i);
      int on_len, p, r;
      case (m_mode[i])
         1: return 1'b1;
         2: return ((m_t[i] / m_h[i]) % 2) == 0;
         3: begin
            if (m_b[i] == 0) return 1'b0;
            on_len = 2 * m_h[i] * m_b[i];
            p = on_len + 4 * m_h[i];
            r = m_t[i] % p;
            return (r < on_len) && ((r / m_h[i]) % 2 == 0);
         end
         default: return 1'b0;
      endcase
   endfunction

   task automatic cycle();
      bit tk;
      int p;
      @(posedge clk);
      if (rst) begin
         cyc = 0;
         exp_done = '0;
         for (int i = 0; i < N_CH; i++) begin
            m_mode[i] = 0; m_h[i] = 1;
            m_b[i] = 0;    m_t[i] = 0;
         end
      end else begin
         cyc++;
         tk = (cyc % DIV) == 0;
         for (int i = 0; i < N_CH; i++) begin
            exp_done[i] = 1'b0;
            if (cfg.cfg_we && int'(cfg.cfg_ch) == i) begin
               m_mode[i] = int'(cfg.cfg_mode);
               m_h[i] = (cfg.cfg_half == 0) ? 1
                      : int'(cfg.cfg_half);
               m_b[i] = int'(cfg.cfg_burst);
               m_t[i] = 0;
            end else if (tk) begin
               m_t[i]++;
               if (m_mode[i] == 3 && m_b[i] != 0) begin
                  p = 2 * m_h[i] * m_b[i] + 4 * m_h[i];
                  if (m_t[i] % p == 2 * m_h[i] * m_b[i])
                     exp_done[i] = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < N_CH; i++) exp_led[i] = model_led(i);
      #1;
      chk("led", 32'(led), 32'(exp_led ^ INV));
      chk("done", 32'(burst_done), 32'(exp_done));
   endtask

   task automatic wr(input int ch, input int mode,
                     input int half, input int b);
      cfg.cfg_we    = 1'b1;
      cfg.cfg_ch    = CH_W'(ch);
      cfg.cfg_mode  = 2'(mode);
      cfg.cfg_half  = HALF_W'(half);
      cfg.cfg_burst = BURST_W'(b);
      cycle();
      cfg.cfg_we = 1'b0;
   endtask

   initial begin
      int n, last, tog, sum;
      logic prev;
      logic [N_CH-1:0] snap;
      cfg.cfg_we = 1'b0; cfg.cfg_ch = '0;
      cfg.cfg_mode = '0; cfg.cfg_half = '0;
      cfg.cfg_burst = '0;
      repeat (3) cycle();
      chk("rst_led", 32'(led), 32'(INV));
      rst = 1'b0;

      // reset mid-blink, then prescaler restart
      wr(1, 2, 2, 0);
      repeat (17) cycle();
      rst = 1'b1;
      repeat (3) cycle();
      chk("rst2_led", 32'(led), 32'(INV));
      chk("rst2_done", 32'(burst_done), 0);
      rst = 1'b0;
      wr(0, 2, 1, 0);
      n = 1;
      while (ledhi[0] && n < 20) begin
         cycle();
         n++;
      end
      chk("first_tick", n, DIV);

      // blink timing, H=3
      wr(0, 2, 3, 0);
      chk("blink_start", 32'(ledhi[0]), 1);
      prev = ledhi[0]; last = -1; tog = 0;
      for (int k = 0; k < 140; k++) begin
         cycle();
         if (ledhi[0] != prev) begin
            if (last >= 0) chk("blink_half", k - last, 12);
            last = k; tog++;
         end
         prev = ledhi[0];
      end
      chk("blink_toggles", 32'(tog >= 10), 1);

      // write on a tick cycle while ch0 blinks
      n = 0;
      while ((cyc + 1) % DIV != 0 && n < DIV) begin
         cycle();
         n++;
      end
      wr(1, 1, 0, 0);
      chk("ch1_on_tick", 32'(ledhi[1]), 1);

      // burst H=1, 3 flashes
      wr(2, 3, 1, 3);
      sum = 0;
      repeat (200) begin
         cycle();
         sum += int'(burst_done[2]);
      end
      chk("burst_done_cnt", sum, 5);

      // mid-burst switch to OFF
      repeat (7) cycle();
      wr(2, 0, 0, 0);
      chk("burst_off", 32'(ledhi[2]), 0);
      sum = 0;
      repeat (60) begin
         cycle();
         sum += int'(burst_done[2]);
      end
      chk("off_no_done", sum, 0);

      // half=0 acts as H=1; burst=0 stays dark
      wr(0, 2, 0, 0);
      repeat (40) cycle();
      wr(2, 3, 2, 0);
      sum = 0;
      repeat (60) begin
         cycle();
         sum += int'(burst_done[2]) + int'(ledhi[2]);
      end
      chk("burst0_quiet", sum, 0);

      // out-of-range channel on a non-tick edge
      while ((cyc + 1) % DIV == 0) cycle();
      snap = led;
      wr(3, 1, 5, 2);
      chk("bad_ch", 32'(led), 32'(snap));

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            wr($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 3));
         end else begin
            cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
